serial_io_bridge: RTL and testbench



---
 rtl/serial_io_bridge.sv | 120 ++++++++++++
 tb/tb_serial_io_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_io_bridge.sv
// Two first-word-fall-through byte FIFOs bridging the processor serial ports and a host byte channel.
// Optional SERIAL_IO_ERR_EN builds sticky overflow/underflow flags; otherwise those outputs are tied to 0.
module serial_io_bridge #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [7:0]    serial_in,
    output logic          serial_valid_in,
    output logic          serial_ready_in,
    input  logic [7:0]    serial_out,
    input  logic          serial_rden_out,
    input  logic          serial_wren_out,
    input  logic [7:0]    host_rx_data,
    input  logic          host_rx_valid,
    output logic          host_rx_ready,
    output logic [7:0]    host_tx_data,
    output logic          host_tx_valid,
    input  logic          host_tx_ready,
    output logic [AW:0]   rx_count,
    output logic [AW:0]   tx_count,
    output logic          err_overflow,
    output logic          err_underflow
);

    localparam int unsigned CW = AW + 1;

    // Index 0 is the RX FIFO (host -> processor), index 1 is the TX FIFO (processor -> host).
    logic [1:0]         push_req;
    logic [1:0]         pop_req;
    logic [1:0][7:0]    wdata;
    logic [1:0][7:0]    head;
    logic [1:0][CW-1:0] cnt;
    logic [1:0]         full;
    logic [1:0]         empty;

    assign push_req = {serial_wren_out, host_rx_valid};
    assign pop_req  = {host_tx_ready, serial_rden_out};
    assign wdata    = {serial_out, host_rx_data};

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [7:0]    mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [CW-1:0] count_q;
        logic          push_en;
        logic          pop_en;

        // Full/empty come from the pre-edge count, so push-on-full and pop-on-empty are simply masked.
        assign full[g]  = (count_q == CW'(DEPTH));
        assign empty[g] = (count_q == '0);
        assign push_en  = push_req[g] & ~full[g];
        assign pop_en   = pop_req[g] & ~empty[g];
        assign head[g]  = empty[g] ? 8'h00 : mem[rd_ptr];
        assign cnt[g]   = count_q;

        always_ff @(posedge clock) begin
            if (push_en) begin
                mem[wr_ptr] <= wdata[g];
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_en) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push_en, pop_en})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign serial_in       = head[0];
    assign serial_valid_in = ~empty[0];
    assign host_rx_ready   = ~full[0];
    assign rx_count        = cnt[0];
    assign host_tx_data    = head[1];
    assign host_tx_valid   = ~empty[1];
    assign serial_ready_in = ~full[1];
    assign tx_count        = cnt[1];

`ifdef SERIAL_IO_ERR_EN
    logic err_ovf_q;
    logic err_unf_q;

    // Only processor-side misuse is flagged; the host handshake can never overrun RX.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            if (serial_wren_out & full[1]) begin
                err_ovf_q <= 1'b1;
            end
            if (serial_rden_out & empty[0]) begin
                err_unf_q <= 1'b1;
            end
        end
    end

    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_io_bridge.sv
// Directed self-checking bench for serial_io_bridge (DEPTH=8); honours SERIAL_IO_ERR_EN for flag expectations.
module tb_serial_io_bridge;

    localparam int unsigned DEPTH = 8;
`ifdef SERIAL_IO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] serial_in;
    logic       serial_valid_in;
    logic       serial_ready_in;
    logic [7:0] serial_out = 8'h00;
    logic       serial_rden_out = 1'b0;
    logic       serial_wren_out = 1'b0;
    logic [7:0] host_rx_data = 8'h00;
    logic       host_rx_valid = 1'b0;
    logic       host_rx_ready;
    logic [7:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready = 1'b0;
    logic [3:0] rx_count;
    logic [3:0] tx_count;
    logic       err_overflow;
    logic       err_underflow;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    serial_io_bridge #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_ready_in (serial_ready_in),
        .serial_out      (serial_out),
        .serial_rden_out (serial_rden_out),
        .serial_wren_out (serial_wren_out),
        .host_rx_data    (host_rx_data),
        .host_rx_valid   (host_rx_valid),
        .host_rx_ready   (host_rx_ready),
        .host_tx_data    (host_tx_data),
        .host_tx_valid   (host_tx_valid),
        .host_tx_ready   (host_tx_ready),
        .rx_count        (rx_count),
        .tx_count        (tx_count),
        .err_overflow    (err_overflow),
        .err_underflow   (err_underflow)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rx_count"}, 32'(rx_count), 32'd0);
        check({tag, "_tx_count"}, 32'(tx_count), 32'd0);
        check({tag, "_serial_valid_in"}, 32'(serial_valid_in), 32'd0);
        check({tag, "_host_tx_valid"}, 32'(host_tx_valid), 32'd0);
        check({tag, "_serial_in"}, 32'(serial_in), 32'd0);
        check({tag, "_host_tx_data"}, 32'(host_tx_data), 32'd0);
        check({tag, "_serial_ready_in"}, 32'(serial_ready_in), 32'd1);
        check({tag, "_host_rx_ready"}, 32'(host_rx_ready), 32'd1);
        check({tag, "_err_overflow"}, 32'(err_overflow), 32'd0);
        check({tag, "_err_underflow"}, 32'(err_underflow), 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        check_idle("reset");
        tick();
        reset = 1'b1;
        tick();

        // RX path: three host bytes, then three processor pops
        host_rx_valid = 1'b1;
        host_rx_data  = 8'h41;
        tick();
        check("rx_first_data", 32'(serial_in), 32'h41);
        check("rx_first_valid", 32'(serial_valid_in), 32'd1);
        check("rx_first_count", 32'(rx_count), 32'd1);
        host_rx_data = 8'h42;
        tick();
        host_rx_data = 8'h43;
        tick();
        host_rx_valid = 1'b0;
        check("rx_three_count", 32'(rx_count), 32'd3);
        check("rx_three_head", 32'(serial_in), 32'h41);
        serial_rden_out = 1'b1;
        tick();
        check("rx_pop1", 32'(serial_in), 32'h42);
        tick();
        check("rx_pop2", 32'(serial_in), 32'h43);
        tick();
        serial_rden_out = 1'b0;
        check("rx_pop3_data", 32'(serial_in), 32'h00);
        check("rx_pop3_valid", 32'(serial_valid_in), 32'd0);
        check("rx_pop3_count", 32'(rx_count), 32'd0);

        // RX fill to full, rejected host push, then wrap
        host_rx_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            host_rx_data = 8'(k);
            tick();
        end
        check("rx_full_ready", 32'(host_rx_ready), 32'd0);
        check("rx_full_count", 32'(rx_count), 32'd8);
        host_rx_data = 8'hEE;
        tick();
        host_rx_valid = 1'b0;
        check("rx_full_reject_count", 32'(rx_count), 32'd8);
        check("rx_full_no_ovf", 32'(err_overflow), 32'd0);
        serial_rden_out = 1'b1;
        tick();
        tick();
        serial_rden_out = 1'b0;
        check("rx_after_pop2_count", 32'(rx_count), 32'd6);
        host_rx_valid = 1'b1;
        host_rx_data  = 8'h08;
        tick();
        host_rx_data = 8'h09;
        tick();
        host_rx_valid = 1'b0;
        check("rx_wrap_count", 32'(rx_count), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rx_wrap_order%0d", k), 32'(serial_in), 32'(k + 2));
            serial_rden_out = 1'b1;
            tick();
            serial_rden_out = 1'b0;
        end
        check("rx_wrap_empty", 32'(rx_count), 32'd0);

        // RX empty: simultaneous host push and processor pop
        host_rx_valid   = 1'b1;
        host_rx_data    = 8'h5A;
        serial_rden_out = 1'b1;
        tick();
        host_rx_valid   = 1'b0;
        serial_rden_out = 1'b0;
        check("rx_sim_empty_count", 32'(rx_count), 32'd1);
        check("rx_sim_empty_data", 32'(serial_in), 32'h5A);
        check("rx_sim_empty_unf", 32'(err_underflow), 32'(ERR));
        serial_rden_out = 1'b1;
        tick();
        serial_rden_out = 1'b0;

        // Underflow: pop on empty leaves pointers alone
        serial_rden_out = 1'b1;
        tick();
        serial_rden_out = 1'b0;
        check("unf_count", 32'(rx_count), 32'd0);
        check("unf_flag", 32'(err_underflow), 32'(ERR));
        host_rx_valid = 1'b1;
        host_rx_data  = 8'h77;
        tick();
        host_rx_valid = 1'b0;
        check("unf_ptr_intact", 32'(serial_in), 32'h77);
        serial_rden_out = 1'b1;
        tick();
        serial_rden_out = 1'b0;

        // TX full drop
        serial_wren_out = 1'b1;
        for (int k = 0; k < 8; k++) begin
            serial_out = 8'(8'h10 + k);
            tick();
        end
        check("tx_full_ready", 32'(serial_ready_in), 32'd0);
        check("tx_full_count", 32'(tx_count), 32'd8);
        check("tx_full_head", 32'(host_tx_data), 32'h10);
        serial_out = 8'h99;
        tick();
        serial_wren_out = 1'b0;
        check("tx_drop_count", 32'(tx_count), 32'd8);
        check("tx_drop_ovf", 32'(err_overflow), 32'(ERR));
        host_tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("tx_drain%0d", k), 32'(host_tx_data), 32'(8'h10 + k));
            tick();
        end
        host_tx_ready = 1'b0;
        check("tx_drain_valid", 32'(host_tx_valid), 32'd0);
        check("tx_drain_data", 32'(host_tx_data), 32'd0);
        check("tx_drain_count", 32'(tx_count), 32'd0);

        // TX with 3 entries: simultaneous push and pop
        serial_wren_out = 1'b1;
        for (int k = 0; k < 3; k++) begin
            serial_out = 8'(8'hA1 + k);
            tick();
        end
        serial_out    = 8'hA4;
        host_tx_ready = 1'b1;
        tick();
        serial_wren_out = 1'b0;
        check("tx_sim_count", 32'(tx_count), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("tx_sim_order%0d", k), 32'(host_tx_data), 32'(8'hA2 + k));
            tick();
        end
        host_tx_ready = 1'b0;
        check("tx_sim_empty", 32'(tx_count), 32'd0);

        // RX full: simultaneous push and pop drops the push
        host_rx_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            host_rx_data = 8'(8'h20 + k);
            tick();
        end
        host_rx_data    = 8'h30;
        serial_rden_out = 1'b1;
        tick();
        host_rx_valid   = 1'b0;
        serial_rden_out = 1'b0;
        check("rx_sim_full_count", 32'(rx_count), 32'd7);
        check("rx_sim_full_head", 32'(serial_in), 32'h21);

        // Leave TX partly filled, then assert reset between edges
        serial_wren_out = 1'b1;
        serial_out      = 8'hC3;
        tick();
        serial_wren_out = 1'b0;
        check("pre_reset_tx_count", 32'(tx_count), 32'd1);
        reset = 1'b0;
        #2;
        check_idle("async_reset");
        tick();
        reset = 1'b1;
        tick();
        check_idle("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
